layer_compositor: RTL and testbench

Parametrised pixel compositor between the sprite generators (paddles, ball, score digits, …) and the VGA output stage. Each pixel it picks the highest-priority opaque layer, draws an optional playfield border, and applies game-state screens, including a blinking full-screen winner colour timed from the 1 ms tick. The output is registered through a fixed 2-cycle pipeline, and video_on is delayed to match, so blanking stays aligned with the pixel data.

---
 rtl/render_pkg.sv | 12 +
 rtl/blink_timer.sv | 35 +++
 rtl/layer_compositor.sv | 127 ++++++++++++
 tb/tb_layer_compositor.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/render_pkg.sv
// Shared rendering constants: game-state encodings and compositor colour defaults.
package render_pkg;

  localparam logic [1:0] GS_IDLE  = 2'b00;
  localparam logic [1:0] GS_PLAY  = 2'b01;
  localparam logic [1:0] GS_P1WIN = 2'b10;
  localparam logic [1:0] GS_P2WIN = 2'b11;

  localparam int DEF_COLOR_W = 24;
  localparam logic [DEF_COLOR_W-1:0] DEF_KEY_RGB = 24'hFF00FF;

endpackage

// File: rtl/blink_timer.sv
// Winner-screen blink timer: counts 1 ms ticks and toggles phase every BLINK_MS ticks.
module blink_timer #(
  parameter int BLINK_MS = 500
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_1ms,
  input  logic restart,
  output logic phase
);

  localparam int CNT_W = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_MS - 1);

  logic [CNT_W-1:0] cnt;

  // A restart beats a coincident tick so a new state always opens on a full phase-1 period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (restart) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (clk_1ms) begin
      if (cnt == CNT_LAST) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// Pixel compositor: priority layer select, playfield border, game-state screens,
// registered through a fixed 2-cycle pipeline with video_on carried alongside.
module layer_compositor
  import render_pkg::*;
#(
  parameter int                   NUM_LAYERS = 4,
  parameter int                   COLOR_W    = DEF_COLOR_W,
  parameter int                   KEY_EN     = 1,
  parameter logic [COLOR_W-1:0]   KEY_RGB    = COLOR_W'(DEF_KEY_RGB),
  parameter int                   BORDER_W   = 4,
  parameter int                   H_ACTIVE   = 640,
  parameter int                   V_ACTIVE   = 480,
  parameter int                   BLINK_MS   = 500
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [9:0]                    x,
  input  logic [9:0]                    y,
  input  logic                          video_on,
  input  logic                          clk_1ms,
  input  logic [NUM_LAYERS-1:0]         layer_on,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
  input  logic [COLOR_W-1:0]            bg_rgb,
  input  logic [COLOR_W-1:0]            border_rgb,
  input  logic [1:0]                    game_state,
  output logic [COLOR_W-1:0]            rgb,
  output logic                          video_on_out
);

  // With a single layer, player 2's winner colour falls back to layer 0.
  localparam int         P2_IDX    = (NUM_LAYERS > 1) ? 1 : 0;
  localparam bit         BORDER_ON = (BORDER_W > 0);
  localparam logic [9:0] X_LO      = 10'(BORDER_W);
  localparam logic [9:0] X_HI      = 10'(H_ACTIVE - BORDER_W);
  localparam logic [9:0] Y_LO      = 10'(BORDER_W);
  localparam logic [9:0] Y_HI      = 10'(V_ACTIVE - BORDER_W);

  function automatic logic is_keyed(input logic [COLOR_W-1:0] c);
    return (KEY_EN != 0) && (c == KEY_RGB);
  endfunction

  logic [1:0]         prev_state;
  logic               restart;
  logic               phase;
  logic               win_phase;
  logic               layer_hit;
  logic [COLOR_W-1:0] layer_pix;
  logic               in_border;
  logic [COLOR_W-1:0] pix_p0;
  logic [COLOR_W-1:0] pix_p1;
  logic               vld_p1;
  logic [COLOR_W-1:0] rgb_p2;
  logic               vld_p2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev_state <= GS_IDLE;
    else        prev_state <= game_state;
  end

  assign restart = (game_state != prev_state);

  blink_timer #(
    .BLINK_MS (BLINK_MS)
  ) u_blink_timer (
    .clk     (clk),
    .reset   (reset),
    .clk_1ms (clk_1ms),
    .restart (restart),
    .phase   (phase)
  );

  // The pixel sampled with a state change already sees the restarted phase.
  assign win_phase = restart | phase;

  always_comb begin
    layer_hit = 1'b0;
    layer_pix = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_on[i] && !is_keyed(layer_rgb[i*COLOR_W +: COLOR_W])) begin
        layer_hit = 1'b1;
        layer_pix = layer_rgb[i*COLOR_W +: COLOR_W];
      end
    end
  end

  assign in_border = BORDER_ON && ((x < X_LO) || (x >= X_HI) || (y < Y_LO) || (y >= Y_HI));

  always_comb begin
    pix_p0 = '0;
    case (game_state)
      GS_PLAY: begin
        if (layer_hit)      pix_p0 = layer_pix;
        else if (in_border) pix_p0 = border_rgb;
        else                pix_p0 = bg_rgb;
      end
      GS_P1WIN: pix_p0 = win_phase ? layer_rgb[0 +: COLOR_W] : bg_rgb;
      GS_P2WIN: pix_p0 = win_phase ? layer_rgb[P2_IDX*COLOR_W +: COLOR_W] : bg_rgb;
      default:  pix_p0 = '0;
    endcase
  end

  // Stage 1: composited pixel and video_on captured together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      pix_p1 <= pix_p0;
      vld_p1 <= video_on;
    end
  end

  // Stage 2: blank the pixel with its own delayed video_on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_p2 <= '0;
      vld_p2 <= 1'b0;
    end else begin
      rgb_p2 <= vld_p1 ? pix_p1 : '0;
      vld_p2 <= vld_p1;
    end
  end

  assign rgb          = rgb_p2;
  assign video_on_out = vld_p2;

endmodule

// File: tb/tb_layer_compositor.sv
// Scoreboard bench for layer_compositor: a keyed and an unkeyed instance share directed stimulus.
module tb_layer_compositor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic        video_on = 1'b0;
  logic        clk_1ms = 1'b0;
  logic [3:0]  layer_on = '0;
  logic [95:0] layer_rgb = {24'h0000FF, 24'h00FF00, 24'hFF00FF, 24'hFFFFFF};
  logic [23:0] bg_rgb = 24'h111111;
  logic [23:0] border_rgb = 24'hAAAAAA;
  logic [1:0]  game_state = 2'b00;
  logic [23:0] rgb_a, rgb_b;
  logic        vo_a, vo_b;

  logic [24:0] qa[$];
  logic [24:0] qb[$];
  logic        iss = 1'b0;
  logic        iss_d1, iss_d2;
  int          checks = 0;
  int          errors = 0;
  int          na = 0;
  int          nb = 0;

  layer_compositor #(.BLINK_MS(3), .KEY_EN(1)) dut_a (
    .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on), .clk_1ms(clk_1ms),
    .layer_on(layer_on), .layer_rgb(layer_rgb), .bg_rgb(bg_rgb), .border_rgb(border_rgb),
    .game_state(game_state), .rgb(rgb_a), .video_on_out(vo_a)
  );

  layer_compositor #(.BLINK_MS(3), .KEY_EN(0)) dut_b (
    .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on), .clk_1ms(clk_1ms),
    .layer_on(layer_on), .layer_rgb(layer_rgb), .bg_rgb(bg_rgb), .border_rgb(border_rgb),
    .game_state(game_state), .rgb(rgb_b), .video_on_out(vo_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [24:0] act, input logic [24:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got vo=%0b rgb=%06h, expected vo=%0b rgb=%06h",
               nm, act[24], act[23:0], exp[24], exp[23:0]);
    end
  endtask

  // Called on a falling edge: present one pixel, record both expectations, wait one cycle.
  task automatic drive(input logic [9:0] px, input logic [9:0] py, input logic pv,
                       input logic pt, input logic [1:0] pgs, input logic [3:0] pon,
                       input logic [23:0] ea, input logic [23:0] eb);
    x = px; y = py; video_on = pv; clk_1ms = pt; game_state = pgs; layer_on = pon;
    qa.push_back({pv, pv ? ea : 24'h0});
    qb.push_back({pv, pv ? eb : 24'h0});
    iss = 1'b1;
    @(negedge clk);
  endtask

  task automatic stop_issue();
    iss = 1'b0;
    clk_1ms = 1'b0;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      iss_d1 <= 1'b0;
      iss_d2 <= 1'b0;
    end else begin
      iss_d1 <= iss;
      iss_d2 <= iss_d1;
    end
  end

  always @(negedge clk) begin
    if (iss_d2) begin
      if (qa.size() == 0) chk("dutA_underflow", 25'h1, 25'h0);
      else chk($sformatf("dutA_pix%0d", na), {vo_a, rgb_a}, qa.pop_front());
      if (qb.size() == 0) chk("dutB_underflow", 25'h1, 25'h0);
      else chk($sformatf("dutB_pix%0d", nb), {vo_b, rgb_b}, qb.pop_front());
      na++;
      nb++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    #1;
    chk("reset_a", {vo_a, rgb_a}, 25'h0);
    chk("reset_b", {vo_b, rgb_b}, 25'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Priority and colour key (interior pixel).
    drive(10'd100, 10'd100, 1'b1, 1'b0, 2'b01, 4'b0110, 24'h00FF00, 24'hFF00FF);
    drive(10'd100, 10'd100, 1'b1, 1'b0, 2'b01, 4'b0001, 24'hFFFFFF, 24'hFFFFFF);
    drive(10'd100, 10'd100, 1'b1, 1'b0, 2'b01, 4'b1000, 24'h0000FF, 24'h0000FF);
    drive(10'd100, 10'd100, 1'b1, 1'b0, 2'b01, 4'b0010, 24'h111111, 24'hFF00FF);
    drive(10'd100, 10'd100, 1'b1, 1'b0, 2'b01, 4'b1111, 24'hFFFFFF, 24'hFFFFFF);

    // Border edges.
    drive(10'd3,   10'd100, 1'b1, 1'b0, 2'b01, 4'b0000, 24'hAAAAAA, 24'hAAAAAA);
    drive(10'd4,   10'd100, 1'b1, 1'b0, 2'b01, 4'b0000, 24'h111111, 24'h111111);
    drive(10'd636, 10'd100, 1'b1, 1'b0, 2'b01, 4'b0000, 24'hAAAAAA, 24'hAAAAAA);
    drive(10'd635, 10'd100, 1'b1, 1'b0, 2'b01, 4'b0000, 24'h111111, 24'h111111);
    drive(10'd100, 10'd479, 1'b1, 1'b0, 2'b01, 4'b0000, 24'hAAAAAA, 24'hAAAAAA);
    drive(10'd100, 10'd476, 1'b1, 1'b0, 2'b01, 4'b0000, 24'hAAAAAA, 24'hAAAAAA);
    drive(10'd100, 10'd475, 1'b1, 1'b0, 2'b01, 4'b0000, 24'h111111, 24'h111111);
    drive(10'd100, 10'd0,   1'b1, 1'b0, 2'b01, 4'b0000, 24'hAAAAAA, 24'hAAAAAA);

    // Blanking alignment.
    bg_rgb = 24'h123456;
    drive(10'd100, 10'd100, 1'b1, 1'b0, 2'b01, 4'b0000, 24'h123456, 24'h123456);
    drive(10'd100, 10'd100, 1'b1, 1'b0, 2'b01, 4'b0000, 24'h123456, 24'h123456);
    drive(10'd100, 10'd100, 1'b0, 1'b0, 2'b01, 4'b0000, 24'h000000, 24'h000000);
    drive(10'd100, 10'd100, 1'b1, 1'b0, 2'b01, 4'b0000, 24'h123456, 24'h123456);
    drive(10'd100, 10'd100, 1'b1, 1'b0, 2'b01, 4'b0000, 24'h123456, 24'h123456);

    // Idle screen.
    for (int i = 0; i < 3; i++)
      drive(10'd100, 10'd100, 1'b1, 1'b0, 2'b00, 4'b1111, 24'h000000, 24'h000000);

    // Player 1 wins, blink half-period of 3 ticks.
    bg_rgb = 24'h000000;
    drive(10'd100, 10'd100, 1'b1, 1'b0, 2'b10, 4'b0000, 24'hFFFFFF, 24'hFFFFFF);
    drive(10'd100, 10'd100, 1'b1, 1'b1, 2'b10, 4'b0000, 24'hFFFFFF, 24'hFFFFFF);
    drive(10'd100, 10'd100, 1'b1, 1'b0, 2'b10, 4'b0000, 24'hFFFFFF, 24'hFFFFFF);
    drive(10'd100, 10'd100, 1'b1, 1'b1, 2'b10, 4'b0000, 24'hFFFFFF, 24'hFFFFFF);
    drive(10'd100, 10'd100, 1'b1, 1'b1, 2'b10, 4'b0000, 24'hFFFFFF, 24'hFFFFFF);
    drive(10'd100, 10'd100, 1'b1, 1'b0, 2'b10, 4'b0000, 24'h000000, 24'h000000);
    drive(10'd100, 10'd100, 1'b1, 1'b1, 2'b10, 4'b0000, 24'h000000, 24'h000000);
    drive(10'd100, 10'd100, 1'b1, 1'b1, 2'b10, 4'b0000, 24'h000000, 24'h000000);
    drive(10'd100, 10'd100, 1'b1, 1'b1, 2'b10, 4'b0000, 24'h000000, 24'h000000);
    drive(10'd100, 10'd100, 1'b1, 1'b0, 2'b10, 4'b0000, 24'hFFFFFF, 24'hFFFFFF);
    drive(10'd100, 10'd100, 1'b1, 1'b1, 2'b10, 4'b0000, 24'hFFFFFF, 24'hFFFFFF);
    drive(10'd100, 10'd100, 1'b1, 1'b1, 2'b10, 4'b0000, 24'hFFFFFF, 24'hFFFFFF);
    drive(10'd100, 10'd100, 1'b1, 1'b1, 2'b10, 4'b0000, 24'hFFFFFF, 24'hFFFFFF);
    drive(10'd100, 10'd100, 1'b1, 1'b0, 2'b10, 4'b0000, 24'h000000, 24'h000000);

    // Switch to player 2 on a tick: restarts at phase 1 with layer 1 (key ignored).
    drive(10'd100, 10'd100, 1'b1, 1'b1, 2'b11, 4'b0000, 24'hFF00FF, 24'hFF00FF);
    drive(10'd100, 10'd100, 1'b1, 1'b0, 2'b11, 4'b0000, 24'hFF00FF, 24'hFF00FF);
    drive(10'd100, 10'd100, 1'b1, 1'b1, 2'b11, 4'b0000, 24'hFF00FF, 24'hFF00FF);
    drive(10'd100, 10'd100, 1'b1, 1'b1, 2'b11, 4'b0000, 24'hFF00FF, 24'hFF00FF);
    drive(10'd100, 10'd100, 1'b1, 1'b1, 2'b11, 4'b0000, 24'hFF00FF, 24'hFF00FF);
    drive(10'd100, 10'd100, 1'b1, 1'b0, 2'b11, 4'b0000, 24'h000000, 24'h000000);

    // Reset in the middle of play with a lit pixel on the output.
    for (int i = 0; i < 4; i++)
      drive(10'd100, 10'd100, 1'b1, 1'b0, 2'b01, 4'b0001, 24'hFFFFFF, 24'hFFFFFF);
    stop_issue();
    #2;
    chk("pre_reset_a", {vo_a, rgb_a}, {1'b1, 24'hFFFFFF});
    reset = 1'b0;
    #1;
    chk("async_reset_a", {vo_a, rgb_a}, 25'h0);
    chk("async_reset_b", {vo_b, rgb_b}, 25'h0);
    qa.delete();
    qb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("release_a", {vo_a, rgb_a}, 25'h0);
    drive(10'd100, 10'd100, 1'b1, 1'b0, 2'b01, 4'b0001, 24'hFFFFFF, 24'hFFFFFF);
    chk("release_1cyc_a", {vo_a, rgb_a}, 25'h0);
    chk("release_1cyc_b", {vo_b, rgb_b}, 25'h0);
    drive(10'd100, 10'd100, 1'b1, 1'b0, 2'b01, 4'b0110, 24'h00FF00, 24'hFF00FF);
    drive(10'd2,   10'd100, 1'b1, 1'b0, 2'b01, 4'b0000, 24'hAAAAAA, 24'hAAAAAA);
    stop_issue();
    repeat (4) @(negedge clk);

    chk("drain_a", 25'(qa.size()), 25'h0);
    chk("drain_b", 25'(qb.size()), 25'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
